// File: rtl/mem_pkg.sv
// Memory-bus control word shared by the CPU data path and the framebuffer write port.
package mem_pkg;

  typedef struct packed {
    logic       memWrite;
    logic [1:0] size;
  } mem_ctrl_t;

endpackage

// File: rtl/vga_pkg.sv
// Framebuffer geometry, fill-engine state encoding and address helpers.
package vga_pkg;

  localparam int         FB_ROWS   = 120;
  localparam int         FB_WCOLS  = 20;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {IDLE, CHECK, FILL, DONE} fill_state_t;

  // Row in [14:8], word column in [6:2]; bit 7 stays clear because WCOLS*4 < 128.
  function automatic logic [31:0] fill_addr(input logic [4:0] x, input logic [6:0] y);
    return {17'b0, y, 1'b0, x, 2'b00};
  endfunction

endpackage

// File: rtl/vga_fill_walker.sv
// Raster walker over an inclusive rectangle: word column x runs X0..X1, then the row advances.
module vga_fill_walker (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic       i_advance,
  input  logic [4:0] i_x0,
  input  logic [4:0] i_x1,
  input  logic [6:0] i_y0,
  input  logic [6:0] i_y1,
  output logic [4:0] o_x,
  output logic [6:0] o_y,
  output logic       o_last
);

  logic [4:0] r_x;
  logic [6:0] r_y;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_load) begin
      r_x <= i_x0;
      r_y <= i_y0;
    end else if (i_advance) begin
      if (r_x == i_x1) begin
        r_x <= i_x0;
        r_y <= r_y + 7'd1;
      end else begin
        r_x <= r_x + 5'd1;
      end
    end
  end

  assign o_x    = r_x;
  assign o_y    = r_y;
  assign o_last = (r_x == i_x1) && (r_y == i_y1);

endmodule

// File: rtl/vga_fill_ctrl.sv
// Framebuffer write-port arbiter: CPU stores pass straight through, rectangle fill uses idle cycles.
// Optional VGA_FILL_IRQ_EN adds a sticky completion interrupt (o_fillIrq / i_irqAck).
module vga_fill_ctrl
  import mem_pkg::*;
  import vga_pkg::*;
#(
  parameter int ROWS  = FB_ROWS,
  parameter int WCOLS = FB_WCOLS
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_cpuAddr,
  input  logic [31:0] i_cpuData,
  input  mem_ctrl_t   i_cpuCtrl,
  input  logic        i_cpuEn,
  input  logic        i_fillStart,
  input  logic [4:0]  i_fillX0,
  input  logic [4:0]  i_fillX1,
  input  logic [6:0]  i_fillY0,
  input  logic [6:0]  i_fillY1,
  input  logic [3:0]  i_fillColor,
  input  logic        i_fillAbort,
  output logic [31:0] o_pxlAddr,
  output logic [31:0] o_pxlData,
  output mem_ctrl_t   o_ctrlVGA,
  output logic        o_en_MEM,
  output logic        o_busy,
  output logic        o_fillDone,
  output logic        o_fillErr
`ifdef VGA_FILL_IRQ_EN
  ,
  output logic        o_fillIrq,
  input  logic        i_irqAck
`endif
);

  fill_state_t r_state, w_state_next;
  logic [4:0]  r_x0, r_x1;
  logic [6:0]  r_y0, r_y1;
  logic [3:0]  r_color;
  logic        r_err, w_err_next;
  logic        w_cpuWr, w_valid, w_load, w_advance, w_last, w_fill_sel;
  logic [4:0]  w_x;
  logic [6:0]  w_y;

  assign w_cpuWr = i_cpuEn & i_cpuCtrl.memWrite;
  assign w_valid = (r_x0 <= r_x1) && (32'(r_x1) < 32'(WCOLS)) &&
                   (r_y0 <= r_y1) && (32'(r_y1) < 32'(ROWS));

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_err_next   = 1'b0;
    case (r_state)
      IDLE:  if (i_fillStart) w_state_next = CHECK;
      CHECK: begin
        if (i_fillAbort) begin
          w_state_next = IDLE;
        end else if (w_valid) begin
          w_state_next = FILL;
          w_load       = 1'b1;
        end else begin
          w_state_next = IDLE;
          w_err_next   = 1'b1;
        end
      end
      // Abort wins over completion even when the final word goes out this cycle.
      FILL: begin
        if (i_fillAbort)            w_state_next = IDLE;
        else if (!w_cpuWr && w_last) w_state_next = DONE;
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_err   <= 1'b0;
      r_x0    <= '0;
      r_x1    <= '0;
      r_y0    <= '0;
      r_y1    <= '0;
      r_color <= '0;
    end else begin
      r_state <= w_state_next;
      r_err   <= w_err_next;
      if (r_state == IDLE && i_fillStart) begin
        r_x0    <= i_fillX0;
        r_x1    <= i_fillX1;
        r_y0    <= i_fillY0;
        r_y1    <= i_fillY1;
        r_color <= i_fillColor;
      end
    end
  end

  assign w_fill_sel = (r_state == FILL) && !w_cpuWr;
  assign w_advance  = w_fill_sel;

  vga_fill_walker u_walker (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_load    (w_load),
    .i_advance (w_advance),
    .i_x0      (r_x0),
    .i_x1      (r_x1),
    .i_y0      (r_y0),
    .i_y1      (r_y1),
    .o_x       (w_x),
    .o_y       (w_y),
    .o_last    (w_last)
  );

  // Combinational mux keeps CPU stores at zero added latency.
  always_comb begin
    o_pxlAddr = i_cpuAddr;
    o_pxlData = i_cpuData;
    o_ctrlVGA = i_cpuCtrl;
    o_en_MEM  = i_cpuEn;
    if (w_fill_sel) begin
      o_pxlAddr          = fill_addr(w_x, w_y);
      o_pxlData          = {8{r_color}};
      o_ctrlVGA.memWrite = 1'b1;
      o_ctrlVGA.size     = SIZE_WORD;
      o_en_MEM           = 1'b1;
    end
  end

  assign o_busy     = (r_state != IDLE);
  assign o_fillDone = (r_state == DONE);
  assign o_fillErr  = r_err;

`ifdef VGA_FILL_IRQ_EN
  logic r_irq;

  always_ff @(posedge i_clk) begin
    if (i_rst)                     r_irq <= 1'b0;
    else if (w_state_next == DONE) r_irq <= 1'b1;
    else if (i_irqAck)             r_irq <= 1'b0;
  end

  assign o_fillIrq = r_irq | o_fillDone;
`endif

endmodule
